// File: rtl/trigmot_pkg.sv
// Shared definitions for the motion-trigger qualification stages:
// FSM state encodings, event counter sizing and a saturating increment.
package trigmot_pkg;

  // Qualifier FSM states (3-bit encoding kept stable for legacy consumers)
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ARMING    = 3'd1;
  localparam logic [2:0] ACTIVE    = 3'd2;
  localparam logic [2:0] RELEASING = 3'd3;
  localparam logic [2:0] HOLDOFF   = 3'd4;

  // Event / statistics counter sizing
  localparam int          EVT_CNT_W   = 16;
  localparam logic [15:0] EVT_CNT_MAX = 16'hFFFF;

  // Increment that sticks at all-ones instead of wrapping to zero
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    logic [15:0] res;
    if (val == EVT_CNT_MAX) begin
      res = val;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/trigmot_frame_edge.sv
// Frame boundary detector for frame_valid-framed streams.
// frame_start marks the first cycle of a frame, frame_end the first idle
// cycle after a frame whose start was observed. A frame that is already in
// progress when reset is released produces neither edge, so partial frames
// are never evaluated downstream.
module trigmot_frame_edge (
  input  logic clk,
  input  logic reset,
  input  logic frame_valid,
  output logic frame_start,
  output logic frame_end
);

  logic fv_d_r;
  logic seen_start_r;
  logic low_seen_r;

  // A rising edge only counts once frame_valid has been seen low since reset
  assign frame_start = frame_valid & ~fv_d_r & low_seen_r;
  assign frame_end   = ~frame_valid & fv_d_r & seen_start_r;

  // Delay frame_valid and remember whether a genuine frame start occurred
  always_ff @(posedge clk) begin
    if (reset) begin
      fv_d_r       <= 1'b0;
      seen_start_r <= 1'b0;
      low_seen_r   <= 1'b0;
    end else begin
      fv_d_r <= frame_valid;
      if (!frame_valid) begin
        low_seen_r <= 1'b1;
      end else begin
        low_seen_r <= low_seen_r;
      end
      if (frame_start) begin
        seen_start_r <= 1'b1;
      end else begin
        seen_start_r <= seen_start_r;
      end
    end
  end

endmodule

// File: rtl/trigmot_event_qual.sv
// Debounces the per-frame motion trigger into motion events.
// An event starts after ON_FRAMES consecutive motion frames, ends after
// OFF_FRAMES consecutive quiet frames, and is followed by HOLDOFF_FRAMES
// frames during which motion is ignored. Evaluation happens once per frame
// at frame_end; outputs are registered one cycle later.
// Optional build macro TRIGMOT_QUAL_STATS_EN enables the motion_frames
// statistics counter; without it the port is tied to zero.
module trigmot_event_qual #(
  parameter int ON_FRAMES      = 3,
  parameter int OFF_FRAMES     = 5,
  parameter int HOLDOFF_FRAMES = 10,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        trigger_in,
  input  logic        frame_valid,
  input  logic        data_valid,
  output logic        motion_active,
  output logic        event_start,
  output logic        event_end,
  output logic [15:0] event_count,
  output logic [15:0] motion_frames
);

  import trigmot_pkg::*;

  localparam logic [CNT_W-1:0] ON_C   = CNT_W'(ON_FRAMES);
  localparam logic [CNT_W-1:0] OFF_C  = CNT_W'(OFF_FRAMES);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLDOFF_FRAMES);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

  // Per-frame action selected by the FSM
  localparam logic [1:0] ACT_NONE  = 2'd0;
  localparam logic [1:0] ACT_START = 2'd1;
  localparam logic [1:0] ACT_END   = 2'd2;

  logic             frame_start_s;
  logic             frame_end_s;
  logic             hit_s;
  logic             frame_motion_r;

  logic [2:0]       state_r;
  logic [2:0]       state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [1:0]       action_s;

  logic             motion_active_r;
  logic             motion_active_nx_s;
  logic             event_start_r;
  logic             event_start_nx_s;
  logic             event_end_r;
  logic             event_end_nx_s;
  logic [15:0]      event_count_r;
  logic [15:0]      event_count_nx_s;

  trigmot_frame_edge u_frame_edge (
    .clk         (clk),
    .reset       (reset),
    .frame_valid (frame_valid),
    .frame_start (frame_start_s),
    .frame_end   (frame_end_s)
  );

  // Only triggers accompanied by valid frame data count as motion
  assign hit_s     = trigger_in & frame_valid & data_valid;
  assign cnt_inc_s = cnt_r + ONE_C;

  // Sticky per-frame motion flag; restarted at each frame start so that
  // triggers from an unevaluated partial frame cannot leak forward
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_motion_r <= 1'b0;
    end else if (!enable) begin
      frame_motion_r <= 1'b0;
    end else if (frame_start_s) begin
      frame_motion_r <= hit_s;
    end else if (frame_end_s) begin
      frame_motion_r <= 1'b0;
    end else if (hit_s) begin
      frame_motion_r <= 1'b1;
    end else begin
      frame_motion_r <= frame_motion_r;
    end
  end

  // Next-state, counter and output computation; disable overrides evaluation
  always_comb begin
    state_nx_s         = state_r;
    cnt_nx_s           = cnt_r;
    action_s           = ACT_NONE;
    motion_active_nx_s = motion_active_r;
    event_start_nx_s   = 1'b0;
    event_end_nx_s     = 1'b0;
    event_count_nx_s   = event_count_r;

    if (!enable) begin
      state_nx_s         = IDLE;
      cnt_nx_s           = ZERO_C;
      motion_active_nx_s = 1'b0;
      event_end_nx_s     = motion_active_r;
    end else if (frame_end_s) begin
      case (state_r)
        IDLE: begin
          if (frame_motion_r) begin
            if (ON_C == ONE_C) begin
              action_s = ACT_START;
            end else begin
              state_nx_s = ARMING;
              cnt_nx_s   = ONE_C;
            end
          end else begin
            state_nx_s = IDLE;
            cnt_nx_s   = ZERO_C;
          end
        end
        ARMING: begin
          if (frame_motion_r) begin
            if (cnt_inc_s == ON_C) begin
              action_s = ACT_START;
            end else begin
              cnt_nx_s = cnt_inc_s;
            end
          end else begin
            state_nx_s = IDLE;
            cnt_nx_s   = ZERO_C;
          end
        end
        ACTIVE: begin
          if (frame_motion_r) begin
            state_nx_s = ACTIVE;
          end else if (OFF_C == ONE_C) begin
            action_s = ACT_END;
          end else begin
            state_nx_s = RELEASING;
            cnt_nx_s   = ONE_C;
          end
        end
        RELEASING: begin
          if (frame_motion_r) begin
            state_nx_s = ACTIVE;
            cnt_nx_s   = ZERO_C;
          end else if (cnt_inc_s == OFF_C) begin
            action_s = ACT_END;
          end else begin
            cnt_nx_s = cnt_inc_s;
          end
        end
        HOLDOFF: begin
          if (cnt_inc_s == HOLD_C) begin
            state_nx_s = IDLE;
            cnt_nx_s   = ZERO_C;
          end else begin
            cnt_nx_s = cnt_inc_s;
          end
        end
        default: begin
          state_nx_s = IDLE;
          cnt_nx_s   = ZERO_C;
        end
      endcase

      case (action_s)
        ACT_START: begin
          state_nx_s         = ACTIVE;
          cnt_nx_s           = ZERO_C;
          motion_active_nx_s = 1'b1;
          event_start_nx_s   = 1'b1;
          event_count_nx_s   = sat_inc16(event_count_r);
        end
        ACT_END: begin
          state_nx_s         = (HOLD_C == ZERO_C) ? IDLE : HOLDOFF;
          cnt_nx_s           = ZERO_C;
          motion_active_nx_s = 1'b0;
          event_end_nx_s     = 1'b1;
        end
        default: begin
          event_start_nx_s = 1'b0;
          event_end_nx_s   = 1'b0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      cnt_r           <= ZERO_C;
      motion_active_r <= 1'b0;
      event_start_r   <= 1'b0;
      event_end_r     <= 1'b0;
      event_count_r   <= 16'd0;
    end else begin
      state_r         <= state_nx_s;
      cnt_r           <= cnt_nx_s;
      motion_active_r <= motion_active_nx_s;
      event_start_r   <= event_start_nx_s;
      event_end_r     <= event_end_nx_s;
      event_count_r   <= event_count_nx_s;
    end
  end

  assign motion_active = motion_active_r;
  assign event_start   = event_start_r;
  assign event_end     = event_end_r;
  assign event_count   = event_count_r;

`ifdef TRIGMOT_QUAL_STATS_EN
  logic [15:0] motion_frames_r;

  // Count every evaluated frame that carried motion, whatever the FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      motion_frames_r <= 16'd0;
    end else if (frame_end_s && frame_motion_r) begin
      motion_frames_r <= sat_inc16(motion_frames_r);
    end else begin
      motion_frames_r <= motion_frames_r;
    end
  end

  assign motion_frames = motion_frames_r;
`else
  assign motion_frames = 16'd0;
`endif

endmodule

// File: tb/tb_trigmot_event_qual.sv
// Self-checking bench for trigmot_event_qual (default parameters).
// A streak-based reference model predicts the outputs after every frame;
// predictions are queued when a frame is closed and compared when the DUT
// has registered its response.
module tb_trigmot_event_qual;

  localparam int ON_F   = 3;
  localparam int OFF_F  = 5;
  localparam int HOLD_F = 10;

  typedef struct {
    bit st;
    bit en;
    bit act;
    int cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        trigger_in = 1'b0;
  logic        frame_valid = 1'b0;
  logic        data_valid = 1'b0;
  logic        motion_active;
  logic        event_start;
  logic        event_end;
  logic [15:0] event_count;
  logic [15:0] motion_frames;

  int n_cmp = 0;
  int n_err = 0;

  exp_t sb_q[$];

  // reference model state
  bit m_act = 1'b0;
  int m_cnt = 0;
  int m_mf = 0;
  int m_on_streak = 0;
  int m_off_streak = 0;
  int m_hold_left = 0;

  trigmot_event_qual #(
    .ON_FRAMES(ON_F), .OFF_FRAMES(OFF_F), .HOLDOFF_FRAMES(HOLD_F), .CNT_W(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .trigger_in    (trigger_in),
    .frame_valid   (frame_valid),
    .data_valid    (data_valid),
    .motion_active (motion_active),
    .event_start   (event_start),
    .event_end     (event_end),
    .event_count   (event_count),
    .motion_frames (motion_frames)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_mf();
`ifdef TRIGMOT_QUAL_STATS_EN
    return m_mf;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_cnt = 0; m_mf = 0;
    m_on_streak = 0; m_off_streak = 0; m_hold_left = 0;
  endtask

  // Predict outputs for one evaluated frame
  task automatic model_frame(input bit mot, output exp_t e);
    e.st = 1'b0;
    e.en = 1'b0;
    if (mot) m_mf++;
    if (m_hold_left > 0) begin
      m_hold_left--;
    end else if (!m_act) begin
      m_on_streak = mot ? m_on_streak + 1 : 0;
      if (m_on_streak == ON_F) begin
        m_act = 1'b1;
        e.st = 1'b1;
        m_on_streak = 0;
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      m_off_streak = mot ? 0 : m_off_streak + 1;
      if (m_off_streak == OFF_F) begin
        m_act = 1'b0;
        e.en = 1'b1;
        m_off_streak = 0;
        m_hold_left = HOLD_F;
      end
    end
    e.act = m_act;
    e.cnt = m_cnt;
  endtask

  // Wait for the registered response to a pushed prediction and compare
  task automatic compare_next(input string tag);
    exp_t e;
    @(posedge clk); #1;
    check_val({tag, "_sb_depth"}, sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({tag, "_start"}, event_start, e.st);
      check_val({tag, "_end"}, event_end, e.en);
      check_val({tag, "_active"}, motion_active, e.act);
      check_val({tag, "_count"}, event_count, e.cnt);
    end
    @(posedge clk); #1;
    check_val({tag, "_start_width"}, event_start, 1'b0);
    check_val({tag, "_end_width"}, event_end, 1'b0);
  endtask

  // One frame: optional trigger pulse, data_valid level, then an idle gap
  // carrying a trigger that must be ignored
  task automatic run_frame(input bit trig, input bit dv);
    exp_t e;
    @(negedge clk);
    frame_valid = 1'b1;
    data_valid  = dv;
    repeat (2) @(negedge clk);
    trigger_in = trig;
    @(negedge clk);
    trigger_in = 1'b0;
    repeat (2) @(negedge clk);
    frame_valid = 1'b0;
    data_valid  = 1'b0;
    model_frame(trig & dv, e);
    sb_q.push_back(e);
    compare_next("frame");
    @(negedge clk);
    trigger_in = 1'b1;
    data_valid = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    data_valid = 1'b0;
  endtask

  initial begin
    exp_t e;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("rst_active", motion_active, 1'b0);
    check_val("rst_start", event_start, 1'b0);
    check_val("rst_end", event_end, 1'b0);
    check_val("rst_count", event_count, 16'd0);
    check_val("rst_mf", motion_frames, 16'd0);

    // event start after three motion frames
    repeat (3) run_frame(1'b1, 1'b1);
    // quiet run ends it
    repeat (5) run_frame(1'b0, 1'b1);
    // holdoff ignores motion, then a fresh event arms and starts
    repeat (10) run_frame(1'b1, 1'b1);
    repeat (3) run_frame(1'b1, 1'b1);
    // interrupted quiet run keeps the event alive
    repeat (4) run_frame(1'b0, 1'b1);
    run_frame(1'b1, 1'b1);
    repeat (4) run_frame(1'b0, 1'b1);
    run_frame(1'b1, 1'b1);
    check_val("mf_before_disable", motion_frames, exp_mf());

    // disable while active: end pulse, count retained
    @(negedge clk);
    enable = 1'b0;
    m_act = 1'b0; m_on_streak = 0; m_off_streak = 0; m_hold_left = 0;
    e.st = 1'b0; e.en = 1'b1; e.act = 1'b0; e.cnt = m_cnt;
    sb_q.push_back(e);
    compare_next("disable");
    @(negedge clk);
    enable = 1'b1;

    // two motion frames, then a trigger without data_valid (quiet)
    repeat (2) run_frame(1'b1, 1'b1);
    run_frame(1'b1, 1'b0);
    repeat (3) run_frame(1'b1, 1'b1);

    // reset during a frame carrying motion: that frame is not evaluated
    @(negedge clk);
    frame_valid = 1'b1;
    data_valid  = 1'b1;
    trigger_in  = 1'b1;
    reset       = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    trigger_in = 1'b0;
    repeat (2) @(negedge clk);
    frame_valid = 1'b0;
    data_valid  = 1'b0;
    e.st = 1'b0; e.en = 1'b0; e.act = 1'b0; e.cnt = 0;
    sb_q.push_back(e);
    compare_next("partial");
    check_val("partial_mf", motion_frames, 16'd0);

    // counter must start from zero: only the third motion frame starts
    repeat (3) run_frame(1'b1, 1'b1);
    check_val("final_mf", motion_frames, exp_mf());
    check_val("final_sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
